// File: rtl/gate_arb_pkg.sv
// Shared opcode encoding and slot state type for the gate-op arbiter.
package gate_arb_pkg;
   localparam int OPW = 3;

   localparam logic [OPW-1:0] OP_AND     = 3'd0;
   localparam logic [OPW-1:0] OP_OR      = 3'd1;
   localparam logic [OPW-1:0] OP_NAND    = 3'd2;
   localparam logic [OPW-1:0] OP_NOR     = 3'd3;
   localparam logic [OPW-1:0] OP_XOR     = 3'd4;
   localparam logic [OPW-1:0] OP_XNOR    = 3'd5;
   localparam logic [OPW-1:0] OP_NOT     = 3'd6;
   localparam logic [OPW-1:0] OP_ILLEGAL = 3'd7;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_t;
endpackage

// File: rtl/gate_logic_unit.sv
// Combinational bitwise logic unit; illegal opcodes yield zero with err set.
module gate_logic_unit
   import gate_arb_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [OPW-1:0]   op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y,
   output logic             err
);
   always_comb begin
      y   = '0;
      err = 1'b0;
      case (op)
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_NAND: y = ~(a & b);
         OP_NOR:  y = ~(a | b);
         OP_XOR:  y = a ^ b;
         OP_XNOR: y = ~(a ^ b);
         OP_NOT:  y = ~a;
         default: err = 1'b1;
      endcase
   end
endmodule

// File: rtl/gate_op_arbiter.sv
// Round-robin arbiter sharing one logic unit among NREQ requesters, one-deep response slot.
// Optional: define GATE_ARB_PRIO0_EN to give requester 0 strict priority.
module gate_op_arbiter
   import gate_arb_pkg::*;
#(
   parameter  int NREQ  = 4,
   parameter  int WIDTH = 8,
   localparam int IDW   = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [OPW*NREQ-1:0]   req_op,
   input  logic [WIDTH*NREQ-1:0] req_a,
   input  logic [WIDTH*NREQ-1:0] req_b,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic [WIDTH-1:0]      rsp_data,
   output logic                  rsp_err
);
`ifdef GATE_ARB_PRIO0_EN
   localparam int RR_FIRST = 1;
`else
   localparam int RR_FIRST = 0;
`endif

   slot_state_t      state_reg, state_next;
   logic [IDW-1:0]   ptr_reg, ptr_next;
   logic [IDW-1:0]   win;
   logic             found;
   logic             can_accept;
   logic             grant;
   logic [OPW-1:0]   sel_op;
   logic [WIDTH-1:0] sel_a, sel_b;
   logic [WIDTH-1:0] lu_y;
   logic             lu_err;

   // Two passes give the wrap-around search: indices >= ptr first, then the rest.
   always_comb begin
      found = 1'b0;
      win   = '0;
`ifdef GATE_ARB_PRIO0_EN
      if (req_valid[0]) begin
         found = 1'b1;
      end
`endif
      for (int i = RR_FIRST; i < NREQ; i++) begin
         if (!found && req_valid[i] && i >= int'(ptr_reg)) begin
            found = 1'b1;
            win   = i[IDW-1:0];
         end
      end
      for (int i = RR_FIRST; i < NREQ; i++) begin
         if (!found && req_valid[i]) begin
            found = 1'b1;
            win   = i[IDW-1:0];
         end
      end
   end

   assign can_accept = (state_reg == SLOT_EMPTY) || rsp_ready;
   assign grant      = found && can_accept && !rst;
   assign rsp_valid  = (state_reg == SLOT_FULL);

   always_comb begin
      req_ready = '0;
      sel_op    = '0;
      sel_a     = '0;
      sel_b     = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win == i[IDW-1:0]) begin
            req_ready[i] = grant;
            sel_op       = req_op[OPW*i +: OPW];
            sel_a        = req_a[WIDTH*i +: WIDTH];
            sel_b        = req_b[WIDTH*i +: WIDTH];
         end
      end
   end

   gate_logic_unit #(.WIDTH(WIDTH)) u_logic (
      .op  (sel_op),
      .a   (sel_a),
      .b   (sel_b),
      .y   (lu_y),
      .err (lu_err)
   );

   always_comb begin
      ptr_next = ptr_reg;
`ifdef GATE_ARB_PRIO0_EN
      if (grant && win != '0) begin
`else
      if (grant) begin
`endif
         ptr_next = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         SLOT_EMPTY: if (grant) state_next = SLOT_FULL;
         SLOT_FULL:  if (rsp_ready && !grant) state_next = SLOT_EMPTY;
         default:    state_next = SLOT_EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= SLOT_EMPTY;
         ptr_reg   <= '0;
      end else begin
         state_reg <= state_next;
         ptr_reg   <= ptr_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_id   <= '0;
         rsp_data <= '0;
         rsp_err  <= 1'b0;
      end else if (grant) begin
         rsp_id   <= win;
         rsp_data <= lu_y;
         rsp_err  <= lu_err;
      end
   end
endmodule

// File: tb/tb_gate_op_arbiter.sv
// Randomized scoreboard bench for gate_op_arbiter; honours GATE_ARB_PRIO0_EN when defined.
module tb_gate_op_arbiter;
   localparam int NREQ  = 4;
   localparam int WIDTH = 8;
   localparam int IDW   = 2;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic [NREQ-1:0]       req_valid = '0;
   logic [NREQ-1:0]       req_ready;
   logic [3*NREQ-1:0]     req_op = '0;
   logic [WIDTH*NREQ-1:0] req_a = '0;
   logic [WIDTH*NREQ-1:0] req_b = '0;
   logic                  rsp_valid;
   logic                  rsp_ready = 1'b0;
   logic [IDW-1:0]        rsp_id;
   logic [WIDTH-1:0]      rsp_data;
   logic                  rsp_err;

   gate_op_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         id;
      logic [7:0] data;
      logic       err;
   } rsp_t;

   rsp_t exp_q[$];
   rsp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   m_ptr  = 0;
   bit   m_full = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

   function automatic logic [7:0] ref_result(input logic [2:0] op, input logic [7:0] a,
                                             input logic [7:0] b);
      case (op)
         3'd0:    return a & b;
         3'd1:    return a | b;
         3'd2:    return ~(a & b);
         3'd3:    return ~(a | b);
         3'd4:    return a ^ b;
         3'd5:    return ~(a ^ b);
         3'd6:    return ~a;
         default: return 8'h00;
      endcase
   endfunction

   // Winner = first valid requester scanning from ptr with wrap (index 0 first if prioritized).
   function automatic int ref_pick(input logic [NREQ-1:0] v, input int p);
`ifdef GATE_ARB_PRIO0_EN
      if (v[0]) return 0;
`endif
      for (int k = 0; k < NREQ; k++) begin
         int idx = (p + k) % NREQ;
`ifdef GATE_ARB_PRIO0_EN
         if (idx != 0 && v[idx]) return idx;
`else
         if (v[idx]) return idx;
`endif
      end
      return -1;
   endfunction

   // Called at posedge+1; drives one cycle, checks, updates the model, returns at next posedge+1.
   task automatic step(input logic [NREQ-1:0] v, input logic [3*NREQ-1:0] ops,
                       input logic [WIDTH*NREQ-1:0] av, input logic [WIDTH*NREQ-1:0] bv,
                       input logic rdy);
      int w;
      bit g;
      logic [NREQ-1:0] exp_ready;
      rsp_t e;
      req_valid = v;
      req_op    = ops;
      req_a     = av;
      req_b     = bv;
      rsp_ready = rdy;
      #2;
      w = ref_pick(v, m_ptr);
      g = (w >= 0) && (!m_full || rdy);
      exp_ready = g ? (NREQ'(1) << w) : '0;
      check("req_ready", 32'(req_ready), 32'(exp_ready));
      check("rsp_valid", 32'(rsp_valid), 32'(m_full));
      if (m_full && exp_q.size() > 0) begin
         check("hold_id", 32'(rsp_id), 32'(exp_q[0].id));
         check("hold_data", 32'(rsp_data), 32'(exp_q[0].data));
      end
      if (g) begin
         e.id   = w;
         e.err  = (ops[3*w +: 3] == 3'd7);
         e.data = ref_result(ops[3*w +: 3], av[8*w +: 8], bv[8*w +: 8]);
         exp_q.push_back(e);
`ifdef GATE_ARB_PRIO0_EN
         if (w != 0) m_ptr = (w + 1) % NREQ;
`else
         m_ptr = (w + 1) % NREQ;
`endif
      end
      m_full = g || (m_full && !rdy);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (!rst && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp actual=id%0d/%0h required=none", rsp_id, rsp_data);
         end else begin
            mon_e = exp_q.pop_front();
            $display("rsp id=%0d data=%02h err=%0b", rsp_id, rsp_data, rsp_err);
            check("rsp_id", 32'(rsp_id), 32'(mon_e.id));
            check("rsp_data", 32'(rsp_data), 32'(mon_e.data));
            check("rsp_err", 32'(rsp_err), 32'(mon_e.err));
         end
      end
   end

   logic [WIDTH*NREQ-1:0] ra, rb;
   logic [3*NREQ-1:0]     rop;

   initial begin
      req_valid = '1;
      #3;
      check("rst_valid", 32'(rsp_valid), 0);
      check("rst_id", 32'(rsp_id), 0);
      check("rst_data", 32'(rsp_data), 0);
      check("rst_err", 32'(rsp_err), 0);
      check("rst_ready", 32'(req_ready), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Every opcode through requester 2
      for (int k = 0; k < 7; k++)
         step(4'b0100, {4{3'(k)}}, {4{8'hA5}}, {4{8'h3C}}, 1'b1);
      // Illegal opcode
      step(4'b0001, {4{3'd7}}, {4{8'hFF}}, {4{8'h00}}, 1'b1);
      // Backpressure: slot holds AND result while req 1 waits
      step(4'b0001, {4{3'd0}}, {4{8'hA5}}, {4{8'h3C}}, 1'b1);
      for (int k = 0; k < 3; k++)
         step(4'b0010, {4{3'd1}}, {4{8'h0F}}, {4{8'hF0}}, 1'b0);
      step(4'b0010, {4{3'd1}}, {4{8'h0F}}, {4{8'hF0}}, 1'b1);
      step(4'b0000, '0, '0, '0, 1'b1);

      // Reset mid-transfer with a pending response (ptr left at 3)
      step(4'b0100, {4{3'd4}}, {4{8'h5A}}, {4{8'hFF}}, 1'b0);
      #1 rst = 1'b1;
      #1;
      check("arst_valid", 32'(rsp_valid), 0);
      check("arst_data", 32'(rsp_data), 0);
      check("arst_err", 32'(rsp_err), 0);
      exp_q.delete();
      m_ptr  = 0;
      m_full = 0;
      req_valid = '1;
      #1;
      check("arst_ready", 32'(req_ready), 0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Round-robin with everyone requesting
      for (int k = 0; k < 6; k++) begin
         rop = 12'($urandom);
         ra  = 32'($urandom);
         rb  = 32'($urandom);
         step(4'b1111, rop, ra, rb, 1'b1);
      end

      // Requesters 0 and 3 contending, then 3 alone
      for (int k = 0; k < 4; k++)
         step(4'b1001, {4{3'd1}}, {4{8'h11}}, {4{8'h22}}, 1'b1);
      for (int k = 0; k < 2; k++)
         step(4'b1000, {4{3'd4}}, {4{8'h11}}, {4{8'h33}}, 1'b1);

      // Random traffic
      for (int k = 0; k < 400; k++) begin
         rop = 12'($urandom);
         ra  = 32'($urandom);
         rb  = 32'($urandom);
         step(4'($urandom_range(0, 15)), rop, ra, rb, ($urandom_range(0, 3) != 0));
      end

      for (int k = 0; k < 3; k++)
         step(4'b0000, '0, '0, '0, 1'b1);
      #5;
      check("drain_empty", 32'(exp_q.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
